sdram_access_arbiter: RTL and testbench

- Shares the single SDRAM controller slave port (az_*/za_* side) between three clients:
  - record writer, client 0 (write-only)
  - playback reader, client 1 (read-only)
  - waveform/dump reader, client 2 (read-only)
- Sits between the PlayRecord/Display logic and the sdram instance.
- Round-robin arbitration, Avalon-style waitrequest handling, in-order routing of pipelined read data back to the issuing client.

---
 rtl/sdram_access_arbiter.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_sdram_access_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_access_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
//  Module   : sdram_access_arbiter
//  Purpose  : Shares the single SDRAM controller slave port (az_*/za_*) among
//             three clients: a record writer (client 0, write-only), a
//             playback reader (client 1) and a waveform/dump reader
//             (client 2). Round-robin grant, Avalon-style waitrequest
//             handling, in-order routing of pipelined read data back to the
//             client that issued the read.
//
//  Ports    : clk, reset_n            clock (CLOCK_50), async active-low reset
//             c0_req/addr/wdata/ack   write client, level request, ack pulse
//             c1_*, c2_*              read clients: req/addr in, ack pulse,
//                                     rdata + rvalid pulse back
//             az_addr/data/rd_n/wr_n  command to the SDRAM controller
//             za_data/valid           read data return from controller
//             za_waitrequest          controller stall
//             rd_underflow            sticky: read data with nothing pending
//
//  Revision : 1.0  initial release
//==============================================================================
module sdram_access_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 16,
  parameter int PEND_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              c0_req,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_ack,

  input  logic              c1_req,
  input  logic [ADDR_W-1:0] c1_addr,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_rvalid,

  input  logic              c2_req,
  input  logic [ADDR_W-1:0] c2_addr,
  output logic              c2_ack,
  output logic [DATA_W-1:0] c2_rdata,
  output logic              c2_rvalid,

  output logic [ADDR_W-1:0] az_addr,
  output logic [DATA_W-1:0] az_data,
  output logic              az_rd_n,
  output logic              az_wr_n,
  input  logic [DATA_W-1:0] za_data,
  input  logic              za_valid,
  input  logic              za_waitrequest,

  output logic              rd_underflow
);

  //--------------------------------------------------------------------------
  // Constants
  //--------------------------------------------------------------------------
  localparam int c_ptr_w = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(PEND_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

  localparam logic [1:0] c_cli_wr  = 2'd0;
  localparam logic [1:0] c_cli_rd1 = 2'd1;
  localparam logic [1:0] c_cli_rd2 = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,   // no command on the bus
    ST_CMD  = 1'b1    // command driven, waiting for waitrequest to drop
  } state_t;

  //--------------------------------------------------------------------------
  // Declarations
  //--------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_owner;      // client that owns the command on the bus
  logic [1:0]          r_rr_ptr;     // first client to consider at next grant
  logic [1:0]          w_owner_nxt;  // client after the owner, wrapping 2 -> 0

  logic                w_rd_room;
  logic [2:0]          w_elig;
  logic                w_grant;
  logic [1:0]          w_sel;
  logic                w_accept;

  // Tag FIFO: one bit per outstanding read, 0 = client 1, 1 = client 2.
  logic [PEND_DEPTH-1:0] r_tag_mem;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head;

  //--------------------------------------------------------------------------
  // Eligibility and round-robin selection
  //--------------------------------------------------------------------------
  // Reads are only eligible while the tag FIFO has room. Because at most one
  // command is ever in flight, a read granted here always finds room when it
  // is accepted.
  assign w_rd_room = (r_count != c_cnt_full);

  always_comb begin
    w_elig  = {c2_req & w_rd_room, c1_req & w_rd_room, c0_req};
    w_grant = |w_elig;
    w_sel   = c_cli_wr;
    case (r_rr_ptr)
      c_cli_rd1: begin
        if      (w_elig[1]) w_sel = c_cli_rd1;
        else if (w_elig[2]) w_sel = c_cli_rd2;
        else                w_sel = c_cli_wr;
      end
      c_cli_rd2: begin
        if      (w_elig[2]) w_sel = c_cli_rd2;
        else if (w_elig[0]) w_sel = c_cli_wr;
        else                w_sel = c_cli_rd1;
      end
      default: begin
        if      (w_elig[0]) w_sel = c_cli_wr;
        else if (w_elig[1]) w_sel = c_cli_rd1;
        else                w_sel = c_cli_rd2;
      end
    endcase
  end

  assign w_owner_nxt = (r_owner == c_cli_rd2) ? c_cli_wr : (r_owner + 2'd1);

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state and acknowledge pulses
  //--------------------------------------------------------------------------
  // The ack is combinational so the client sees it in the very cycle the
  // controller takes the command; it can then drop or change its request on
  // the following edge.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    c0_ack      = 1'b0;
    c1_ack      = 1'b0;
    c2_ack      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!za_waitrequest) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_IDLE;
          case (r_owner)
            c_cli_wr:  c0_ack = 1'b1;
            c_cli_rd1: c1_ack = 1'b1;
            default:   c2_ack = 1'b1;
          endcase
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Command register toward the controller
  //--------------------------------------------------------------------------
  // Address/data are captured at grant and held for the whole CMD state, so a
  // client changing its inputs after grant has no effect on the bus.
  // az_data is only reloaded for writes; during reads it keeps its old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      az_addr  <= '0;
      az_data  <= '0;
      az_rd_n  <= 1'b1;
      az_wr_n  <= 1'b1;
      r_owner  <= c_cli_wr;
      r_rr_ptr <= c_cli_wr;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner <= w_sel;
            case (w_sel)
              c_cli_wr: begin
                az_addr <= c0_addr;
                az_data <= c0_wdata;
                az_wr_n <= 1'b0;
              end
              c_cli_rd1: begin
                az_addr <= c1_addr;
                az_rd_n <= 1'b0;
              end
              default: begin
                az_addr <= c2_addr;
                az_rd_n <= 1'b0;
              end
            endcase
          end
        end
        ST_CMD: begin
          if (w_accept) begin
            az_rd_n  <= 1'b1;
            az_wr_n  <= 1'b1;
            r_rr_ptr <= w_owner_nxt;
          end
        end
        default: begin
          az_rd_n <= 1'b1;
          az_wr_n <= 1'b1;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Tag FIFO of outstanding reads
  //--------------------------------------------------------------------------
  // Data returned while the FIFO is empty cannot be attributed to anyone and
  // is therefore not a pop; it only raises rd_underflow.
  assign w_push = w_accept & (r_owner != c_cli_wr);
  assign w_pop  = za_valid & (r_count != c_cnt_zero);
  assign w_head = r_tag_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_mem <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_tag_mem[r_wr_ptr] <= (r_owner == c_cli_rd2);
        r_wr_ptr            <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Read data return (one cycle after za_valid)
  //--------------------------------------------------------------------------
  // The rdata of the client not targeted keeps its previous value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c1_rdata     <= '0;
      c1_rvalid    <= 1'b0;
      c2_rdata     <= '0;
      c2_rvalid    <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      c1_rvalid <= 1'b0;
      c2_rvalid <= 1'b0;
      if (w_pop) begin
        if (w_head) begin
          c2_rdata  <= za_data;
          c2_rvalid <= 1'b1;
        end else begin
          c1_rdata  <= za_data;
          c1_rvalid <= 1'b1;
        end
      end
      if (za_valid && (r_count == c_cnt_zero)) begin
        rd_underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_access_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
//  Module   : tb_sdram_access_arbiter
//  Purpose  : Self-checking bench for sdram_access_arbiter. A transaction-level
//             model (command slot, round-robin pointer, queue of pending read
//             owners) predicts every output each cycle; directed scenarios add
//             literal expectations, followed by a randomized traffic phase.
//  Revision : 1.0  initial release
//==============================================================================
module tb_sdram_access_arbiter;

  localparam int ADDR_W     = 22;
  localparam int DATA_W     = 16;
  localparam int PEND_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              c0_req, c1_req, c2_req;
  logic [ADDR_W-1:0] c0_addr, c1_addr, c2_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic              c0_ack, c1_ack, c2_ack;
  logic [DATA_W-1:0] c1_rdata, c2_rdata;
  logic              c1_rvalid, c2_rvalid;
  logic [ADDR_W-1:0] az_addr;
  logic [DATA_W-1:0] az_data;
  logic              az_rd_n, az_wr_n;
  logic [DATA_W-1:0] za_data;
  logic              za_valid, za_waitrequest;
  logic              rd_underflow;

  always #5 clk = ~clk;

  sdram_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PEND_DEPTH(PEND_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_ack(c0_ack),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_ack(c1_ack),
    .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
    .c2_req(c2_req), .c2_addr(c2_addr), .c2_ack(c2_ack),
    .c2_rdata(c2_rdata), .c2_rvalid(c2_rvalid),
    .az_addr(az_addr), .az_data(az_data), .az_rd_n(az_rd_n), .az_wr_n(az_wr_n),
    .za_data(za_data), .za_valid(za_valid), .za_waitrequest(za_waitrequest),
    .rd_underflow(rd_underflow)
  );

  //--------------------------------------------------------------------------
  // Check bookkeeping
  //--------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  //--------------------------------------------------------------------------
  // Behavioural model: one command slot, a round-robin "next" pointer and a
  // queue holding the owner id of each accepted, not yet returned read.
  //--------------------------------------------------------------------------
  bit                m_busy;
  int                m_owner;
  int                m_ptr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_pendq[$];
  bit                m_rv[3];
  logic [DATA_W-1:0] m_rd[3];
  bit                m_under;

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_addr  = '0;
    m_data  = '0;
    m_pendq.delete();
    for (int i = 0; i < 3; i++) begin
      m_rv[i] = 1'b0;
      m_rd[i] = '0;
    end
    m_under = 1'b0;
  endfunction

  task automatic compare_outputs();
    bit ack_now;
    ack_now = m_busy && !za_waitrequest;
    chk("az_rd_n", az_rd_n, !(m_busy && m_owner != 0));
    chk("az_wr_n", az_wr_n, !(m_busy && m_owner == 0));
    chk("az_addr", az_addr, m_addr);
    chk("az_data", az_data, m_data);
    chk("c0_ack", c0_ack, ack_now && m_owner == 0);
    chk("c1_ack", c1_ack, ack_now && m_owner == 1);
    chk("c2_ack", c2_ack, ack_now && m_owner == 2);
    chk("c1_rvalid", c1_rvalid, m_rv[1]);
    chk("c2_rvalid", c2_rvalid, m_rv[2]);
    chk("c1_rdata", c1_rdata, m_rd[1]);
    chk("c2_rdata", c2_rdata, m_rd[2]);
    chk("rd_underflow", rd_underflow, m_under);
  endtask

  // What the coming clock edge does, given the inputs now on the pins.
  function automatic void model_advance();
    bit [2:0] req;
    int       sz;
    bit       found;
    int       c;
    int       h;
    req   = {c2_req, c1_req, c0_req};
    sz    = m_pendq.size();
    found = 1'b0;
    m_rv[1] = 1'b0;
    m_rv[2] = 1'b0;
    if (za_valid) begin
      if (sz > 0) begin
        h       = m_pendq.pop_front();
        m_rv[h] = 1'b1;
        m_rd[h] = za_data;
      end else begin
        m_under = 1'b1;
      end
    end
    if (m_busy) begin
      if (!za_waitrequest) begin
        if (m_owner != 0) m_pendq.push_back(m_owner);
        m_ptr  = (m_owner + 1) % 3;
        m_busy = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        c = (m_ptr + k) % 3;
        if (!found && req[c] && (c == 0 || sz < PEND_DEPTH)) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_owner = c;
          case (c)
            0: begin m_addr = c0_addr; m_data = c0_wdata; end
            1: m_addr = c1_addr;
            default: m_addr = c2_addr;
          endcase
        end
      end
    end
  endfunction

  // Single compare process: outputs are settled 2 ns after each falling edge.
  always @(negedge clk) begin
    #2;
    if (!reset_n) begin
      model_reset();
      compare_outputs();
    end else begin
      compare_outputs();
      model_advance();
    end
  end

  //--------------------------------------------------------------------------
  // Stimulus engine
  //--------------------------------------------------------------------------
  bit [2:0] want;        // clients generating random traffic
  int       p_req;       // % chance an idle client raises a request
  int       p_wait;      // % chance of waitrequest in a cycle
  int       p_valid;     // % chance of read data when reads are pending
  bit       auto_valid;
  bit [2:0] last_ack;

  task automatic step();
    @(negedge clk);
    if (last_ack[0]) c0_req = 1'b0;
    if (last_ack[1]) c1_req = 1'b0;
    if (last_ack[2]) c2_req = 1'b0;
    if (want[0] && !c0_req && $urandom_range(99) < p_req) begin
      c0_req = 1'b1; c0_addr = ADDR_W'($urandom); c0_wdata = DATA_W'($urandom);
    end
    if (want[1] && !c1_req && $urandom_range(99) < p_req) begin
      c1_req = 1'b1; c1_addr = ADDR_W'($urandom);
    end
    if (want[2] && !c2_req && $urandom_range(99) < p_req) begin
      c2_req = 1'b1; c2_addr = ADDR_W'($urandom);
    end
    za_waitrequest = ($urandom_range(99) < p_wait);
    za_data        = DATA_W'($urandom);
    za_valid       = auto_valid && (m_pendq.size() > 0) && ($urandom_range(99) < p_valid);
  endtask

  task automatic settle();
    #1;
    last_ack = {c2_ack, c1_ack, c0_ack};
  endtask

  task automatic run(input int n);
    repeat (n) begin step(); settle(); end
  endtask

  task automatic do_req(input int n, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int t;
    t = 0;
    step();
    case (n)
      0: begin c0_req = 1'b1; c0_addr = a; c0_wdata = d; end
      1: begin c1_req = 1'b1; c1_addr = a; end
      default: begin c2_req = 1'b1; c2_addr = a; end
    endcase
    settle();
    while (!last_ack[n] && t < 30) begin step(); settle(); t++; end
    chk($sformatf("req%0d_acked", n), last_ack[n], 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    want = 3'b000; auto_valid = 1'b1; p_valid = 100; p_wait = 0;
    while ((m_pendq.size() > 0 || c0_req || c1_req || c2_req) && t < 200) begin
      step(); settle(); t++;
    end
    run(2);
    auto_valid = 1'b0;
    chk("drain_idle", {az_rd_n, az_wr_n}, 2'b11);
  endtask

  //--------------------------------------------------------------------------
  // Directed scenarios followed by random traffic
  //--------------------------------------------------------------------------
  int cnt[3];
  int prev;
  int id;
  int c0_after;

  initial begin
    reset_n = 1'b0;
    c0_req = 1'b0; c1_req = 1'b0; c2_req = 1'b0;
    c0_addr = '0; c1_addr = '0; c2_addr = '0; c0_wdata = '0;
    za_data = '0; za_valid = 1'b0; za_waitrequest = 1'b0;
    want = '0; p_req = 0; p_wait = 0; p_valid = 0; auto_valid = 1'b0; last_ack = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_n", az_rd_n, 1'b1);
    chk("rst_wr_n", az_wr_n, 1'b1);
    chk("rst_addr", az_addr, 0);
    chk("rst_flags", {c0_ack, c1_ack, c2_ack, c1_rvalid, c2_rvalid, rd_underflow}, 0);
    step(); reset_n = 1'b1; settle();

    // Single write
    step(); c0_req = 1'b1; c0_addr = 22'h000123; c0_wdata = 16'hBEEF; settle();
    chk("wr_no_early_ack", c0_ack, 1'b0);
    step(); settle();
    chk("wr_strobe", az_wr_n, 1'b0);
    chk("wr_rd_n", az_rd_n, 1'b1);
    chk("wr_addr", az_addr, 22'h000123);
    chk("wr_data", az_data, 16'hBEEF);
    chk("wr_ack", c0_ack, 1'b1);
    step(); settle();
    chk("wr_release", az_wr_n, 1'b0 ^ 1'b1);
    chk("wr_ack_pulse", c0_ack, 1'b0);

    // Stall: waitrequest held for 5 CMD cycles
    step(); c1_req = 1'b1; c1_addr = 22'h3FFFFF; za_waitrequest = 1'b1; settle();
    for (int i = 0; i < 5; i++) begin
      step(); za_waitrequest = 1'b1; settle();
      chk("stall_rd_n", az_rd_n, 1'b0);
      chk("stall_addr", az_addr, 22'h3FFFFF);
      chk("stall_no_ack", c1_ack, 1'b0);
    end
    step(); settle();
    chk("stall_ack6", c1_ack, 1'b1);
    step(); settle();
    chk("stall_release", az_rd_n, 1'b1);
    chk("stall_pending", m_pendq.size(), 1);
    step(); za_valid = 1'b1; za_data = 16'h1234; settle();
    step(); settle();
    chk("stall_rvalid", c1_rvalid, 1'b1);
    chk("stall_rdata", c1_rdata, 16'h1234);
    chk("stall_c2_quiet", c2_rvalid, 1'b0);
    step(); settle();
    chk("stall_rvalid_pulse", c1_rvalid, 1'b0);

    // In-order routing of read data
    do_req(1, 22'h10, '0);
    do_req(2, 22'h20, '0);
    do_req(1, 22'h30, '0);
    step(); za_valid = 1'b1; za_data = 16'hAAAA; settle();
    step(); za_valid = 1'b1; za_data = 16'hBBBB; settle();
    chk("rt_c1_v0", c1_rvalid, 1'b1);
    chk("rt_c1_d0", c1_rdata, 16'hAAAA);
    step(); za_valid = 1'b1; za_data = 16'hCCCC; settle();
    chk("rt_c2_v", c2_rvalid, 1'b1);
    chk("rt_c2_d", c2_rdata, 16'hBBBB);
    chk("rt_c1_idle", c1_rvalid, 1'b0);
    chk("rt_c1_hold", c1_rdata, 16'hAAAA);
    step(); settle();
    chk("rt_c1_v1", c1_rvalid, 1'b1);
    chk("rt_c1_d1", c1_rdata, 16'hCCCC);
    chk("rt_c2_hold", c2_rdata, 16'hBBBB);

    // Fairness: everybody requesting continuously
    want = 3'b111; p_req = 100; p_wait = 0; auto_valid = 1'b1; p_valid = 100;
    cnt = '{0, 0, 0};
    prev = -1;
    for (int i = 0; i < 24; i++) begin
      step(); settle();
      if (|last_ack) begin
        id = last_ack[0] ? 0 : (last_ack[1] ? 1 : 2);
        if (prev >= 0) chk("fair_order", id, (prev + 1) % 3);
        prev = id;
        cnt[id]++;
      end
    end
    chk("fair_c0", cnt[0], 4);
    chk("fair_c1", cnt[1], 4);
    chk("fair_c2", cnt[2], 4);
    drain();

    // Backpressure: reads stall at PEND_DEPTH, writes keep flowing
    want = 3'b011; p_req = 100; p_wait = 0; auto_valid = 1'b0;
    cnt = '{0, 0, 0};
    c0_after = 0;
    for (int i = 0; i < 40; i++) begin
      step(); settle();
      if (last_ack[1]) cnt[1]++;
      if (last_ack[0] && cnt[1] == PEND_DEPTH) c0_after++;
    end
    chk("bp_reads", cnt[1], PEND_DEPTH);
    chk("bp_writes_flow", c0_after >= 5, 1'b1);
    chk("bp_pending", m_pendq.size(), PEND_DEPTH);
    step(); za_valid = 1'b1; settle();
    cnt[1] = 0;
    for (int i = 0; i < 20; i++) begin
      step(); settle();
      if (last_ack[1]) cnt[1]++;
    end
    chk("bp_one_more", cnt[1], 1);
    drain();

    // Random traffic
    want = 3'b111; p_req = 40; p_wait = 30; auto_valid = 1'b1; p_valid = 50;
    run(600);
    drain();

    // Reset in CMD with two reads pending, then underflow
    do_req(1, 22'h40, '0);
    do_req(2, 22'h50, '0);
    step(); c1_req = 1'b1; c1_addr = 22'h60; za_waitrequest = 1'b1; settle();
    step(); za_waitrequest = 1'b1; settle();
    chk("ru_in_cmd", az_rd_n, 1'b0);
    chk("ru_pending", m_pendq.size(), 2);
    #2;
    reset_n = 1'b0;
    c1_req  = 1'b0;
    #1;
    chk("ru_async_rd_n", az_rd_n, 1'b1);
    chk("ru_async_wr_n", az_wr_n, 1'b1);
    last_ack = '0;
    step(); settle();
    step(); reset_n = 1'b1; settle();
    step(); za_valid = 1'b1; za_data = 16'h5A5A; settle();
    step(); settle();
    chk("ru_no_rvalid", {c2_rvalid, c1_rvalid}, 2'b00);
    chk("ru_underflow", rd_underflow, 1'b1);
    run(3);
    chk("ru_sticky", rd_underflow, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
